// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic DEPTH-stage, WIDTH-bit register pipeline with a
// per-stage valid bit and a valid/ready handshake. Empty stages (bubbles)
// collapse, so a stalled head only blocks the stages directly behind it.
// Words leave in strict FIFO order.
//
// Optional feature: define PIPE_OCC_EN to add the registered occupancy port.
//
// Ports:
//   clk        single clock, all state changes on posedge
//   reset      asynchronous active-high clear of every valid and data register
//   flush      synchronous clear of all valid bits (data left untouched)
//   in_valid   upstream word available
//   in_data    upstream word
//   in_ready   chain accepts in_data this cycle
//   out_valid  last stage holds a word (masked during flush)
//   out_data   last-stage word
//   out_ready  downstream accepts out_data this cycle
//   occupancy  number of valid stages (PIPE_OCC_EN only)
module pipe_reg_chain #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic             v_reg [DEPTH];
  logic [WIDTH-1:0] d_reg [DEPTH];
  logic             v_in  [DEPTH];
  logic [WIDTH-1:0] d_in  [DEPTH];
  logic [DEPTH-1:0] adv;
  logic             in_fire;
  logic             out_fire;

  // A stage may take a new word when it is empty or when its own word moves
  // on. Evaluated from the output backwards so one free slot anywhere ahead
  // lets everything behind it close up.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = ~v_reg[DEPTH-1] | out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = ~v_reg[i] | adv[i+1];
    end
  end

  // Reset is folded in so upstream never sees ready while the chain is held.
  assign in_ready  = adv[0] & ~flush & ~reset;
  assign out_valid = v_reg[DEPTH-1] & ~flush;
  assign out_data  = d_reg[DEPTH-1];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign v_in[gi] = in_fire;
        assign d_in[gi] = in_data;
      end else begin : g_src_prev
        assign v_in[gi] = v_reg[gi-1];
        assign d_in[gi] = d_reg[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_reg[gi] <= 1'b0;
        end else if (flush) begin
          v_reg[gi] <= 1'b0;
        end else if (adv[gi]) begin
          v_reg[gi] <= v_in[gi];
        end
      end

      // Data only moves with a real word, and never on a flush, so an empty
      // stage keeps its old contents rather than capturing garbage.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          d_reg[gi] <= '0;
        end else if (adv[gi] && v_in[gi] && !flush) begin
          d_reg[gi] <= d_in[gi];
        end
      end
    end
  endgenerate

`ifdef PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_reg;

  // Simultaneous in and out leave the count alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_reg <= '0;
    end else if (flush) begin
      occ_reg <= '0;
    end else if (in_fire && !out_fire) begin
      occ_reg <= occ_reg + 1'b1;
    end else if (out_fire && !in_fire) begin
      occ_reg <= occ_reg - 1'b1;
    end
  end

  assign occupancy = occ_reg;
`endif

endmodule
